// File: rtl/rpn_stack_ctrl.sv
// -----------------------------------------------------------------------------
// rpn_stack_ctrl
//   Operand stack and execution sequencer for the RPN calculator. Number tokens
//   from the UART parser are pushed onto an internal stack. Operator tokens
//   present the top stack entries to a combinational ALU for one cycle, then
//   commit the ALU answer back to the stack. Each committed result, or a
//   rejected token, is reported with a one-cycle pulse.
//
// Ports
//   clk, rst_n                  clock (rising edge), synchronous active-low reset
//   in_valid/in_ready           token handshake with the parser
//   in_is_op, in_op, in_data    token payload (operator code or number)
//   alu_op/left/right           registered operands driven to the ALU
//   alu_ans, alu_arg_cnt        combinational ALU answer and operand count
//   res_valid, res_data         result pulse and held result value
//   err_underflow/overflow/div0/unknown   one-cycle error pulses
//   depth                       current number of stack entries
// -----------------------------------------------------------------------------
module rpn_stack_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_is_op,
  input  logic [3:0]               in_op,
  input  logic [WIDTH-1:0]         in_data,
  output logic [3:0]               alu_op,
  output logic [WIDTH-1:0]         alu_left,
  output logic [WIDTH-1:0]         alu_right,
  input  logic [WIDTH-1:0]         alu_ans,
  input  logic [1:0]               alu_arg_cnt,
  output logic                     res_valid,
  output logic [WIDTH-1:0]         res_data,
  output logic                     err_underflow,
  output logic                     err_overflow,
  output logic                     err_div0,
  output logic                     err_unknown,
  output logic [$clog2(DEPTH):0]   depth
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] DEPTH_L = DW'(DEPTH);
  localparam logic [3:0]    OP_DIV  = 4'd3;
  localparam logic [3:0]    OP_POP  = 4'd4;

  typedef enum logic {S_IDLE, S_EXEC} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [WIDTH-1:0]  alu_left_q, alu_left_d;
  logic [WIDTH-1:0]  alu_right_q, alu_right_d;
  logic              res_valid_q, res_valid_d;
  logic [WIDTH-1:0]  res_data_q, res_data_d;
  logic              err_underflow_q, err_underflow_d;
  logic              err_overflow_q, err_overflow_d;
  logic              err_div0_q, err_div0_d;
  logic              err_unknown_q, err_unknown_d;

  // Stack storage: never reset, only entries below depth_q are meaningful.
  logic [WIDTH-1:0]  stack_q [DEPTH];
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [WIDTH-1:0]  wr_data;

  // Indices of the top and next-to-top entries; modular wrap is harmless
  // because they are only used when enough entries exist.
  logic [AW-1:0]     idx_top, idx_nxt;
  logic [WIDTH-1:0]  top_val, nxt_val;

  assign idx_top = depth_q[AW-1:0] - AW'(1);
  assign idx_nxt = depth_q[AW-1:0] - AW'(2);
  assign top_val = stack_q[idx_top];
  assign nxt_val = stack_q[idx_nxt];

  always_comb begin
    state_d         = state_q;
    depth_d         = depth_q;
    alu_op_d        = alu_op_q;
    alu_left_d      = alu_left_q;
    alu_right_d     = alu_right_q;
    res_data_d      = res_data_q;
    res_valid_d     = 1'b0;
    err_underflow_d = 1'b0;
    err_overflow_d  = 1'b0;
    err_div0_d      = 1'b0;
    err_unknown_d   = 1'b0;
    wr_en           = 1'b0;
    wr_addr         = depth_q[AW-1:0];
    wr_data         = in_data;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (!in_is_op) begin
            if (depth_q < DEPTH_L) begin
              wr_en   = 1'b1;
              depth_d = depth_q + DW'(1);
            end else begin
              err_overflow_d = 1'b1;
            end
          end else begin
            // Latch operands now; the ALU settles during EXEC.
            alu_op_d    = in_op;
            alu_right_d = (depth_q >= DW'(1)) ? top_val : '0;
            if (in_op == OP_POP) begin
              alu_left_d = (depth_q >= DW'(1)) ? top_val : '0;
            end else if (depth_q >= DW'(2)) begin
              alu_left_d = nxt_val;
            end else if (depth_q == DW'(1)) begin
              alu_left_d = top_val;
            end else begin
              alu_left_d = '0;
            end
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        state_d = S_IDLE;
        if (alu_arg_cnt == 2'd0) begin
          err_unknown_d = 1'b1;
        end else if (depth_q < DW'(alu_arg_cnt)) begin
          err_underflow_d = 1'b1;
        end else if ((alu_op_q == OP_DIV) && (alu_right_q == '0)) begin
          err_div0_d = 1'b1;
        end else if (alu_arg_cnt == 2'd1) begin
          depth_d     = depth_q - DW'(1);
          res_data_d  = alu_ans;
          res_valid_d = 1'b1;
        end else begin
          // Binary op: answer replaces the left operand slot.
          wr_en       = 1'b1;
          wr_addr     = idx_nxt;
          wr_data     = alu_ans;
          depth_d     = depth_q - DW'(1);
          res_data_d  = alu_ans;
          res_valid_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      depth_q         <= '0;
      alu_op_q        <= 4'hF;
      alu_left_q      <= '0;
      alu_right_q     <= '0;
      res_valid_q     <= 1'b0;
      res_data_q      <= '0;
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
      err_div0_q      <= 1'b0;
      err_unknown_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      depth_q         <= depth_d;
      alu_op_q        <= alu_op_d;
      alu_left_q      <= alu_left_d;
      alu_right_q     <= alu_right_d;
      res_valid_q     <= res_valid_d;
      res_data_q      <= res_data_d;
      err_underflow_q <= err_underflow_d;
      err_overflow_q  <= err_overflow_d;
      err_div0_q      <= err_div0_d;
      err_unknown_q   <= err_unknown_d;
    end
  end

  // Storage writes are gated by reset so an aborted commit leaves no trace.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      stack_q[wr_addr] <= wr_data;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign alu_op        = alu_op_q;
  assign alu_left      = alu_left_q;
  assign alu_right     = alu_right_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign err_underflow = err_underflow_q;
  assign err_overflow  = err_overflow_q;
  assign err_div0      = err_div0_q;
  assign err_unknown   = err_unknown_q;
  assign depth         = depth_q;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
module tb_rpn_stack_ctrl;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_is_op;
  logic [3:0]        in_op;
  logic [WIDTH-1:0]  in_data;
  logic [3:0]        alu_op;
  logic [WIDTH-1:0]  alu_left, alu_right, alu_ans;
  logic [1:0]        alu_arg_cnt;
  logic              res_valid;
  logic [WIDTH-1:0]  res_data;
  logic              err_underflow, err_overflow, err_div0, err_unknown;
  logic [3:0]        depth;

  int checks = 0;
  int errors = 0;

  // Reference model: plain queue used as the operand stack.
  int unsigned       mstk[$];
  logic [WIDTH-1:0]  last_res;

  rpn_stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_op(in_is_op),
    .in_op(in_op), .in_data(in_data),
    .alu_op(alu_op), .alu_left(alu_left), .alu_right(alu_right),
    .alu_ans(alu_ans), .alu_arg_cnt(alu_arg_cnt),
    .res_valid(res_valid), .res_data(res_data),
    .err_underflow(err_underflow), .err_overflow(err_overflow),
    .err_div0(err_div0), .err_unknown(err_unknown),
    .depth(depth)
  );

  always #5 clk = ~clk;

  // Combinational ALU attached to the DUT.
  always_comb begin
    alu_ans     = '0;
    alu_arg_cnt = 2'd0;
    case (alu_op)
      4'd0: begin alu_ans = alu_left + alu_right; alu_arg_cnt = 2'd2; end
      4'd1: begin alu_ans = alu_left - alu_right; alu_arg_cnt = 2'd2; end
      4'd2: begin alu_ans = alu_left * alu_right; alu_arg_cnt = 2'd2; end
      4'd3: begin alu_ans = (alu_right == '0) ? '0 : alu_left / alu_right; alu_arg_cnt = 2'd2; end
      4'd4: begin alu_ans = alu_left; alu_arg_cnt = 2'd1; end
      default: ;
    endcase
  end

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_is_op = 1'b0; in_op = 4'd0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mstk.delete();
    last_res = '0;
  endtask

  task automatic do_push(input logic [WIDTH-1:0] v);
    logic exp_of;
    exp_of = (mstk.size() == DEPTH);
    if (!exp_of) mstk.push_back(v);
    in_valid = 1'b1; in_is_op = 1'b0; in_data = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (err_overflow !== exp_of) begin errors++; $display("FAIL push_overflow got %0b want %0b", err_overflow, exp_of); end
    checks++;
    if (depth !== 4'(mstk.size())) begin errors++; $display("FAIL push_depth got %0d want %0d", depth, mstk.size()); end
    checks++;
    if ({res_valid, err_underflow, err_div0, err_unknown, in_ready} !== 5'b00001) begin
      errors++; $display("FAIL push_flags got %05b want 00001", {res_valid, err_underflow, err_div0, err_unknown, in_ready});
    end
  endtask

  task automatic do_op(input logic [3:0] op);
    int unsigned a, b, r;
    int          argc;
    logic [WIDTH-1:0] exp_left, exp_right;
    logic exp_rv, exp_uf, exp_d0, exp_unk;
    int   n;
    n = mstk.size();
    exp_right = (n >= 1) ? WIDTH'(mstk[n-1]) : '0;
    if (op == 4'd4)  exp_left = exp_right;
    else if (n >= 2) exp_left = WIDTH'(mstk[n-2]);
    else             exp_left = exp_right;
    argc = (op <= 4'd3) ? 2 : (op == 4'd4) ? 1 : 0;
    exp_rv = 0; exp_uf = 0; exp_d0 = 0; exp_unk = 0;
    if (argc == 0) exp_unk = 1;
    else if (n < argc) exp_uf = 1;
    else if (op == 4'd3 && mstk[n-1] == 0) exp_d0 = 1;
    else if (argc == 1) begin
      last_res = WIDTH'(mstk.pop_back()); exp_rv = 1;
    end else begin
      b = mstk.pop_back(); a = mstk.pop_back();
      case (op)
        4'd0: r = (a + b) % 65536;
        4'd1: r = (a + 65536 - b) % 65536;
        4'd2: r = (a * b) % 65536;
        default: r = a / b;
      endcase
      mstk.push_back(r); last_res = WIDTH'(r); exp_rv = 1;
    end

    in_valid = 1'b1; in_is_op = 1'b1; in_op = op;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL exec_ready got %0b want 0", in_ready); end
    checks++;
    if (alu_op !== op) begin errors++; $display("FAIL exec_alu_op got %0h want %0h", alu_op, op); end
    checks++;
    if (alu_right !== exp_right) begin errors++; $display("FAIL exec_alu_right got %0h want %0h", alu_right, exp_right); end
    if (n >= 1) begin
      checks++;
      if (alu_left !== exp_left) begin errors++; $display("FAIL exec_alu_left got %0h want %0h", alu_left, exp_left); end
    end
    checks++;
    if ({res_valid, err_underflow, err_overflow, err_div0, err_unknown} !== 5'b0) begin
      errors++; $display("FAIL exec_pulses got %05b want 00000", {res_valid, err_underflow, err_overflow, err_div0, err_unknown});
    end

    @(posedge clk); #1;
    checks++;
    if ({res_valid, err_underflow, err_overflow, err_div0, err_unknown} !== {exp_rv, exp_uf, 1'b0, exp_d0, exp_unk}) begin
      errors++; $display("FAIL commit_pulses got %05b want %05b",
        {res_valid, err_underflow, err_overflow, err_div0, err_unknown}, {exp_rv, exp_uf, 1'b0, exp_d0, exp_unk});
    end
    checks++;
    if (res_data !== last_res) begin errors++; $display("FAIL commit_res_data got %0h want %0h", res_data, last_res); end
    checks++;
    if (depth !== 4'(mstk.size())) begin errors++; $display("FAIL commit_depth got %0d want %0d", depth, mstk.size()); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL commit_ready got %0b want 1", in_ready); end

    @(posedge clk); #1;
    checks++;
    if ({res_valid, err_underflow, err_overflow, err_div0, err_unknown} !== 5'b0) begin
      errors++; $display("FAIL after_pulses got %05b want 00000", {res_valid, err_underflow, err_overflow, err_div0, err_unknown});
    end
    checks++;
    if (res_data !== last_res) begin errors++; $display("FAIL after_res_hold got %0h want %0h", res_data, last_res); end
  endtask

  task automatic test_reset();
    apply_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (depth !== 4'd0 || alu_op !== 4'hF || alu_left !== '0 || alu_right !== '0) begin
      errors++; $display("FAIL reset_regs got depth=%0d op=%0h l=%0h r=%0h want 0 F 0 0", depth, alu_op, alu_left, alu_right);
    end
    checks++;
    if ({res_valid, err_underflow, err_overflow, err_div0, err_unknown} !== 5'b0 || res_data !== '0) begin
      errors++; $display("FAIL reset_outputs got %05b data=%0h want 00000 0",
        {res_valid, err_underflow, err_overflow, err_div0, err_unknown}, res_data);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_sub();
    apply_reset();
    do_push(16'd3); do_push(16'd4); do_op(4'd1);
    checks++;
    if (res_data !== 16'hFFFF) begin errors++; $display("FAIL sub_value got %0h want ffff", res_data); end
  endtask

  task automatic test_mul_wrap();
    apply_reset();
    do_push(16'h0100); do_push(16'h0100); do_op(4'd2);
    checks++;
    if (res_data !== 16'h0000 || depth !== 4'd1) begin
      errors++; $display("FAIL mul_wrap got %0h depth %0d want 0 depth 1", res_data, depth);
    end
  endtask

  task automatic test_underflow_pop();
    apply_reset();
    do_push(16'd7); do_op(4'd0); do_op(4'd4);
    checks++;
    if (res_data !== 16'd7 || depth !== 4'd0) begin
      errors++; $display("FAIL pop_value got %0h depth %0d want 7 depth 0", res_data, depth);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 1; i <= 9; i++) do_push(WIDTH'(i));
    checks++;
    if (depth !== 4'd8) begin errors++; $display("FAIL overflow_depth got %0d want 8", depth); end
    do_op(4'd4);
    checks++;
    if (res_data !== 16'd8) begin errors++; $display("FAIL overflow_pop got %0h want 8", res_data); end
  endtask

  task automatic test_div0_unknown();
    apply_reset();
    do_push(16'd10); do_push(16'd0); do_op(4'd3); do_op(4'h7);
    checks++;
    if (depth !== 4'd2) begin errors++; $display("FAIL div0_unknown_depth got %0d want 2", depth); end
  endtask

  task automatic test_reset_mid_exec();
    apply_reset();
    do_push(16'd5); do_push(16'd6);
    in_valid = 1'b1; in_is_op = 1'b1; in_op = 4'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || depth !== 4'd0 || alu_op !== 4'hF) begin
      errors++; $display("FAIL abort_state got rv=%0b depth=%0d op=%0h want 0 0 F", res_valid, depth, alu_op);
    end
    rst_n = 1'b1;
    mstk.delete(); last_res = '0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++; $display("FAIL abort_release got ready=%0b rv=%0b want 1 0", in_ready, res_valid);
    end
    do_push(16'd2); do_push(16'd9); do_op(4'd0);
    checks++;
    if (res_data !== 16'd11) begin errors++; $display("FAIL abort_recover got %0h want b", res_data); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] v;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 6) begin
        v = ($urandom_range(0, 4) == 0) ? '0 : WIDTH'($urandom);
        do_push(v);
      end else begin
        do_op(4'($urandom_range(0, 7)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_mul_wrap();
    test_underflow_pop();
    test_overflow();
    test_div0_unknown();
    test_reset_mid_exec();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
